remote_comm_link: RTL and testbench
===================================

# remote_comm_link

Host-side serial command link for the Knight's Tour robot system. It accepts a 16-bit command word, sends it to the robot over a UART line as two 8N1 frames (high byte first), and reports each 8-bit response byte the robot returns. In a system bench it plays the part of the operator's remote and sits between the stimulus and the robot's RX/TX pins.

## Interface
- BAUD_DIV, 2604: clock cycles per UART bit (50 MHz / 19200 baud).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- RX  input  1  serial data from robot; idles high.
- TX  output  1  serial data to robot; idles high.
- cmd  input  16  command word, captured when send_cmd is accepted.
- send_cmd  input  1  one-cycle request to transmit cmd.
- cmd_sent  output  1  level; high once both bytes of the last command have fully left TX.
- resp_rdy  output  1  one-cycle pulse when a response byte has been received.
- resp  output  8  last received response byte; held until the next byte arrives.

## Operation
- Transmit FSM has three states: IDLE, HIGH, LOW.
  - IDLE: on send_cmd, latch cmd into a 16-bit register, clear cmd_sent, start the frame for cmd[15:8], then go to HIGH.
  - HIGH: when that frame's stop bit ends, start the frame for cmd[7:0], then go to LOW.
  - LOW: when its stop bit ends, set cmd_sent and return to IDLE.
- send_cmd is ignored in HIGH and LOW. The latched word is unaffected if cmd changes during transmission.
- TX frame format: start bit 0, then data bits LSB first, then stop bit 1. Each bit is exactly BAUD_DIV cycles.
- Receiver input path: RX passes through a 2-flop synchronizer, both flops reset to 1.
- Receiver operation:
  - A falling edge on the synchronized RX while the receiver is idle starts a frame.
  - Each bit is sampled at its midpoint: first sample BAUD_DIV/2 cycles after the edge, then every BAUD_DIV cycles.
  - 8 data bits are sampled LSB first, then the stop bit.
- At the stop-bit sample:
  - resp is loaded with the data byte.
  - resp_rdy pulses for exactly 1 cycle.
  - The receiver returns to idle.
  - A stop bit sampled as 0 still delivers the byte. There is no error output.
- Receive and transmit are fully independent. A response may arrive while a command is being sent.
- Reset values: TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00. The FSM goes to IDLE and the receiver goes to idle.

## Timing
- The TX start bit of the high byte begins on the cycle after the send_cmd edge is accepted.
- The low-byte start bit begins on the cycle immediately after the high-byte stop bit ends. There is no idle gap.
- cmd_sent rises 2 × 10 × BAUD_DIV cycles after the first start bit began (52080 cycles at the default, ±1).
- cmd_sent stays high until the next accepted send_cmd, which clears it in the same cycle the word is latched.
- resp_rdy pulses about 9.5 × BAUD_DIV cycles after the RX falling edge, plus 2 synchronizer cycles.
- resp changes on the same edge that resp_rdy rises.
- send_cmd and a reset in the same cycle: reset wins and nothing is sent.
- Reset mid-frame:
  - TX returns high on the next cycle and the transmission is abandoned.
  - A partially received byte is discarded and resp_rdy does not pulse.
- Counter widths: baud counter is at least ceil(log2(BAUD_DIV+1)) bits; bit counter is 4 bits.

## Test plan
- Reset: hold rst for 2 cycles -> TX=1, cmd_sent=0, resp_rdy=0, resp=00. Outputs stay stable with RX idle for 100000 cycles.
- Send cmd=16'h2000 -> TX shows frame 0x20, then frame 0x00, each bit 2604 cycles, LSB first. cmd_sent rises about 52080 cycles after send_cmd.
- With TX looped into a second instance's RX, send 16'h5A3C -> receiver gives resp=5A with one resp_rdy pulse, then resp=3C with a second pulse about 26040 cycles later.
- Drive RX with a 0xA5 frame while a command is transmitting -> resp=A5 with one resp_rdy pulse, and the TX frames are undisturbed.
- Pulse send_cmd (cmd=16'h4123) during the high byte of 16'h4522 -> the second request is ignored and the bytes sent are 0x45, 0x22 only.
- Assert rst during the high-byte data bits -> TX=1 on the next cycle, no further frames, and cmd_sent stays 0.

Source files
------------

// File: rtl/remote_comm_link.sv
// Host-side UART command link: sends a 16-bit command as two 8N1 frames (high byte
// first) and reports every byte the robot sends back.
module remote_comm_link #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} tx_state_t;

    tx_state_t      state;
    tx_state_t      next_state;
    logic [7:0]     low_byte;
    logic [9:0]     tx_shift;
    logic [CW-1:0]  tx_baud;
    logic [3:0]     tx_bit;
    logic           frame_done;
    logic           load_frame;
    logic           accept;
    logic           set_sent;
    logic [7:0]     frame_byte;

    logic           rx_meta;
    logic           rx_sync;
    logic           rx_prev;
    logic           rx_busy;
    logic           rx_fall;
    logic [CW-1:0]  rx_cnt;
    logic [3:0]     rx_bit;
    logic [7:0]     rx_shift;

    assign frame_done = (state != IDLE) && (tx_baud == BAUD_LAST) && (tx_bit == 4'd9);
    assign TX         = tx_shift[0];
    assign rx_fall    = rx_prev & ~rx_sync;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_frame = 1'b0;
        accept     = 1'b0;
        set_sent   = 1'b0;
        frame_byte = cmd[15:8];
        case (state)
            IDLE: begin
                if (send_cmd) begin
                    accept     = 1'b1;
                    load_frame = 1'b1;
                    next_state = HIGH;
                end
            end
            HIGH: begin
                if (frame_done) begin
                    load_frame = 1'b1;
                    frame_byte = low_byte;
                    next_state = LOW;
                end
            end
            LOW: begin
                if (frame_done) begin
                    set_sent   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The high byte goes straight into the shifter, so only the low byte needs holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            low_byte <= '0;
            tx_shift <= '1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            cmd_sent <= 1'b0;
        end else begin
            if (accept) begin
                low_byte <= cmd[7:0];
                cmd_sent <= 1'b0;
            end
            if (set_sent) cmd_sent <= 1'b1;
            if (load_frame) begin
                tx_shift <= {1'b1, frame_byte, 1'b0};
                tx_baud  <= '0;
                tx_bit   <= '0;
            end else if (state != IDLE) begin
                if (tx_baud == BAUD_LAST) begin
                    tx_baud  <= '0;
                    tx_bit   <= tx_bit + 4'd1;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                end else begin
                    tx_baud <= tx_baud + CW'(1);
                end
            end
        end
    end

    // Sample 0 is the start bit, 1..8 are data (LSB first), 9 is the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            resp     <= '0;
            resp_rdy <= 1'b0;
        end else begin
            rx_meta  <= RX;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            resp_rdy <= 1'b0;
            if (!rx_busy) begin
                if (rx_fall) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF_LAST;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CW'(1);
            end else begin
                rx_cnt <= BAUD_LAST;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd9) begin
                    resp     <= rx_shift;
                    resp_rdy <= 1'b1;
                    rx_busy  <= 1'b0;
                end else if (rx_bit != 4'd0) begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_remote_comm_link.sv
// Bench for remote_comm_link: a cycle-level model of the expected TX waveform and
// response byte schedule, with a second instance listening on TX as loopback.
module tb_remote_comm_link;

    localparam int BD    = 16;
    localparam int FRAME = 10 * BD;
    localparam int LAT   = 3 + BD / 2 + 9 * BD;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_drive;
    logic        tx;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        peer_tx;
    logic        peer_sent;
    logic        peer_rdy;
    logic [7:0]  peer_resp;

    int          errCount = 0;
    int          checkCount = 0;
    int          cyc = 0;

    bit          mActive = 1'b0;
    bit          mSent = 1'b0;
    int          mK = 0;
    logic [15:0] mWord = '0;
    logic [7:0]  mResp [2];
    exp_t        dutQ [$];
    exp_t        peerQ [$];

    logic        sRst;
    logic        sSend;
    logic [15:0] sCmd;

    always #5 clk = ~clk;

    remote_comm_link #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst(rst), .RX(rx_drive), .TX(tx), .cmd(cmd), .send_cmd(send_cmd),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
    );

    remote_comm_link #(.BAUD_DIV(BD)) u_peer (
        .clk(clk), .rst(rst), .RX(tx), .TX(peer_tx), .cmd(16'h0000), .send_cmd(1'b0),
        .cmd_sent(peer_sent), .resp_rdy(peer_rdy), .resp(peer_resp)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
        end
    endtask

    // Expected line level k cycles after a command was accepted.
    function automatic logic frameBit(input logic [15:0] w, input int k);
        int         f;
        int         b;
        logic [7:0] bv;
        f  = k / FRAME;
        b  = (k % FRAME) / BD;
        bv = (f == 0) ? w[15:8] : w[7:0];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return bv[b-1];
    endfunction

    task automatic checkRx(input int which, input logic rdy, input logic [7:0] r);
        exp_t  q [$];
        exp_t  e;
        string pfx;
        if (which == 0) begin
            q   = dutQ;
            pfx = "dut";
        end else begin
            q   = peerQ;
            pfx = "peer";
        end
        if (rdy) begin
            if (q.size() == 0) begin
                checkOutput({pfx, "_rdy_unexpected"}, 32'(rdy), 32'd0);
            end else begin
                e = q.pop_front();
                checkOutput({pfx, "_rdy_time"}, cyc, e.due);
                mResp[which] = e.data;
            end
        end else if (q.size() != 0 && cyc > q[0].due) begin
            e = q.pop_front();
            checkOutput({pfx, "_rdy_missing"}, 32'(rdy), 32'd1);
            mResp[which] = e.data;
        end
        checkOutput({pfx, "_resp"}, 32'(r), 32'(mResp[which]));
        if (which == 0) dutQ = q;
        else            peerQ = q;
    endtask

    // Inputs are captured at the edge the DUT sees them; outputs are checked 1 ns later.
    always @(posedge clk) begin
        exp_t e;
        sRst  = rst;
        sSend = send_cmd;
        sCmd  = cmd;
        #1;
        cyc++;
        if (sRst) begin
            mActive  = 1'b0;
            mSent    = 1'b0;
            mResp[0] = 8'h00;
            mResp[1] = 8'h00;
            dutQ.delete();
            peerQ.delete();
        end else if (mActive) begin
            mK++;
            if (mK == 2 * FRAME) begin
                mActive = 1'b0;
                mSent   = 1'b1;
            end
        end else if (sSend) begin
            mActive = 1'b1;
            mK      = 0;
            mWord   = sCmd;
            mSent   = 1'b0;
            e.data  = sCmd[15:8];
            e.due   = cyc + LAT;
            peerQ.push_back(e);
            e.data  = sCmd[7:0];
            e.due   = cyc + FRAME + LAT;
            peerQ.push_back(e);
        end
        checkOutput("tx", 32'(tx), 32'(mActive ? frameBit(mWord, mK) : 1'b1));
        checkOutput("cmd_sent", 32'(cmd_sent), 32'(mSent));
        checkRx(0, resp_rdy, resp);
        checkRx(1, peer_rdy, peer_resp);
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        cmd      = w;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        cmd      = 16'($urandom);
    endtask

    task automatic driveRxByte(input logic [7:0] b);
        logic [9:0] fr;
        exp_t       e;
        fr     = {1'b1, b, 1'b0};
        e.data = b;
        e.due  = cyc + LAT;
        dutQ.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rx_drive = fr[i];
            repeat (BD) @(negedge clk);
        end
        rx_drive = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        send_cmd = 1'b0;
        cmd      = 16'h0000;
        rx_drive = 1'b1;
        mResp[0] = 8'h00;
        mResp[1] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released, idling");
        waitCycles(200);

        $display("[TB] directed commands");
        applyStimulus(16'h2000);
        waitCycles(2 * FRAME + 20);
        applyStimulus(16'h5A3C);
        waitCycles(2 * FRAME + 20);

        applyStimulus(16'h4522);
        waitCycles(3 * BD);
        applyStimulus(16'h4123);
        waitCycles(2 * FRAME);

        applyStimulus(16'h9C11);
        waitCycles(BD);
        driveRxByte(8'hA5);
        waitCycles(FRAME + 20);

        $display("[TB] randomized commands with overlapping responses");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'($urandom));
            waitCycles($urandom_range(0, 5 * BD));
            driveRxByte(8'($urandom));
            waitCycles(2 * FRAME);
        end

        $display("[TB] requests near the end of a command");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'($urandom));
            waitCycles(2 * FRAME - 3 + $urandom_range(0, 4));
            applyStimulus(16'($urandom));
            waitCycles(2 * FRAME + 20);
        end

        $display("[TB] reset during high byte");
        applyStimulus(16'h3CC3);
        waitCycles(3 * BD);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitCycles(2 * FRAME + 20);

        $display("[TB] reset and request together");
        rst      = 1'b1;
        cmd      = 16'h7E81;
        send_cmd = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        send_cmd = 1'b0;
        waitCycles(2 * FRAME);

        waitCycles(20);
        checkOutput("dut_pending", dutQ.size(), 32'd0);
        checkOutput("peer_pending", peerQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
